// File: rtl/shift4_deser.sv
// Serial-in, parallel-out receiver for the Shift4 serial path.
// Completed words are held in a one-entry register with a valid/ready handshake.
module shift4_deser #(
  parameter int unsigned size      = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic                       sync,
  input  logic                       ena,
  input  logic                       sin,
  output logic [size-1:0]            q,
  output logic                       q_valid,
  input  logic                       q_ready,
  output logic                       overrun,
  output logic [$clog2(size+1)-1:0]  fill
);

  localparam int unsigned CW = $clog2(size + 1);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  logic [size-1:0] sr, sr_n, shifted, q_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            q_valid_n, overrun_n, done;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sr      <= '0;
      cnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sr      <= sr_n;
      cnt     <= cnt_n;
      q       <= q_n;
      q_valid <= q_valid_n;
      overrun <= overrun_n;
    end
  end

  // Next state: sync beats ena; a completing word may be accepted on the same edge as a drain
  always_comb begin
    sr_n      = sr;
    cnt_n     = cnt;
    q_n       = q;
    q_valid_n = q_valid;
    overrun_n = overrun;
    done      = 1'b0;
    shifted   = LSB_FIRST ? {sin, sr[size-1:1]} : {sr[size-2:0], sin};

    if (sync) begin
      sr_n      = '0;
      cnt_n     = '0;
      overrun_n = 1'b0;
    end else if (ena) begin
      if (cnt == LAST) begin
        done  = 1'b1;
        sr_n  = '0;
        cnt_n = '0;
      end else begin
        sr_n  = shifted;
        cnt_n = cnt + CW'(1);
      end
    end

    if (done && (!q_valid || q_ready)) begin
      q_n       = shifted;
      q_valid_n = 1'b1;
    end else if (done) begin
      overrun_n = 1'b1;
    end else if (q_valid && q_ready) begin
      q_valid_n = 1'b0;
    end
  end

  assign fill = cnt;

endmodule

// File: tb/tb_shift4_deser.sv
// Bench for shift4_deser: LSB-first and MSB-first instances share one stimulus stream.
module tb_shift4_deser;

  localparam int unsigned SZ = 4;
  localparam int unsigned FW = $clog2(SZ + 1);

  logic          clk = 1'b0;
  logic          areset, sync, ena, sin, q_ready;
  logic [SZ-1:0] q_l, q_m;
  logic          v_l, v_m, ov_l, ov_m;
  logic [FW-1:0] f_l, f_m;

  always #5 clk = ~clk;

  shift4_deser #(.size(SZ), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .areset(areset), .sync(sync), .ena(ena), .sin(sin),
    .q(q_l), .q_valid(v_l), .q_ready(q_ready), .overrun(ov_l), .fill(f_l)
  );

  shift4_deser #(.size(SZ), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .areset(areset), .sync(sync), .ena(ena), .sin(sin),
    .q(q_m), .q_valid(v_m), .q_ready(q_ready), .overrun(ov_m), .fill(f_m)
  );

  typedef struct {
    logic       ena, sync, sin, rdy;
    logic [3:0] q, qm;
    logic       v, ov;
    logic [2:0] fill;
  } vec_t;

  vec_t       tbl[$];
  vec_t       sb[$];
  logic [3:0] wsb_l[$], wsb_m[$];
  int         nvec = 0;
  int         nerr = 0;

  function automatic vec_t mk(input logic e, s, d, r, input logic [3:0] eq, eqm,
                              input logic ev, eov, input logic [2:0] ef);
    vec_t t;
    t.ena = e; t.sync = s; t.sin = d; t.rdy = r;
    t.q = eq; t.qm = eqm; t.v = ev; t.ov = eov; t.fill = ef;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic e, s, d, r);
    @(negedge clk);
    ena = e; sync = s; sin = d; q_ready = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected word pair once the DUT reports a valid word
  task automatic check_word(input string name);
    logic [3:0] el, em;
    chk({name, "_valid"}, int'(v_l), 1);
    if (wsb_l.size() == 0 || wsb_m.size() == 0) begin
      chk({name, "_sb_empty"}, 0, 1);
    end else begin
      el = wsb_l.pop_front();
      em = wsb_m.pop_front();
      chk({name, "_q_lsb"}, int'(q_l), int'(el));
      chk({name, "_q_msb"}, int'(q_m), int'(em));
    end
  endtask

  initial begin
    vec_t       e;
    logic [3:0] sh;
    logic [3:0] bits;

    areset = 1'b1; sync = 1'b0; ena = 1'b0; sin = 1'b0; q_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q", int'(q_l), 0);
    chk("reset_valid", int'(v_l), 0);
    chk("reset_overrun", int'(ov_l), 0);
    chk("reset_fill", int'(f_l), 0);
    @(negedge clk);
    areset = 1'b0;

    // Basic LSB-first word 1,0,1,1 then drain
    tbl.push_back(mk(1,0,1,0, 4'h0,4'h0,0,0,1));
    tbl.push_back(mk(1,0,0,0, 4'h0,4'h0,0,0,2));
    tbl.push_back(mk(1,0,1,0, 4'h0,4'h0,0,0,3));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,1,0,0));
    tbl.push_back(mk(0,0,0,0, 4'hD,4'hB,1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'hD,4'hB,0,0,0));
    tbl.push_back(mk(0,0,0,1, 4'hD,4'hB,0,0,0));
    // Gapped word 0,1,1,0 with three idle cycles between bits
    tbl.push_back(mk(1,0,0,0, 4'hD,4'hB,0,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,1,0, 4'hD,4'hB,0,0,1));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,0,0,2));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0, 4'hD,4'hB,0,0,2));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,0,0,3));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0, 4'hD,4'hB,0,0,3));
    tbl.push_back(mk(1,0,0,0, 4'h6,4'h6,1,0,0));
    tbl.push_back(mk(0,0,0,1, 4'h6,4'h6,0,0,0));
    // Overrun: D held, 0000 dropped, then 1,1,1,0 accepted on the drain edge
    tbl.push_back(mk(1,0,1,0, 4'h6,4'h6,0,0,1));
    tbl.push_back(mk(1,0,0,0, 4'h6,4'h6,0,0,2));
    tbl.push_back(mk(1,0,1,0, 4'h6,4'h6,0,0,3));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,1,0,0));
    tbl.push_back(mk(1,0,0,0, 4'hD,4'hB,1,0,1));
    tbl.push_back(mk(1,0,0,0, 4'hD,4'hB,1,0,2));
    tbl.push_back(mk(1,0,0,0, 4'hD,4'hB,1,0,3));
    tbl.push_back(mk(1,0,0,0, 4'hD,4'hB,1,1,0));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,1,1,1));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,1,1,2));
    tbl.push_back(mk(1,0,1,0, 4'hD,4'hB,1,1,3));
    tbl.push_back(mk(1,0,0,1, 4'h7,4'hE,1,1,0));
    tbl.push_back(mk(0,1,0,1, 4'h7,4'hE,0,0,0));
    // sync mid-word with ena high, then 1,1,0,0
    tbl.push_back(mk(1,0,1,0, 4'h7,4'hE,0,0,1));
    tbl.push_back(mk(1,0,1,0, 4'h7,4'hE,0,0,2));
    tbl.push_back(mk(1,1,1,0, 4'h7,4'hE,0,0,0));
    tbl.push_back(mk(1,0,1,0, 4'h7,4'hE,0,0,1));
    tbl.push_back(mk(1,0,1,0, 4'h7,4'hE,0,0,2));
    tbl.push_back(mk(1,0,0,0, 4'h7,4'hE,0,0,3));
    tbl.push_back(mk(1,0,0,0, 4'h3,4'hC,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ena, tbl[i].sync, tbl[i].sin, tbl[i].rdy);
      sb.push_back(tbl[i]);
      step();
      e = sb.pop_front();
      chk($sformatf("v%0d_q_lsb", i), int'(q_l), int'(e.q));
      chk($sformatf("v%0d_q_msb", i), int'(q_m), int'(e.qm));
      chk($sformatf("v%0d_valid", i), int'(v_l), int'(e.v));
      chk($sformatf("v%0d_overrun", i), int'(ov_l), int'(e.ov));
      chk($sformatf("v%0d_fill", i), int'(f_l), int'(e.fill));
    end

    // Drain, then loopback from a Shift4-style source loaded with 1111
    drive(0,0,0,1); step();
    chk("drain_valid", int'(v_l), 0);
    sh = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1,0,sh[0],0);
      sh = sh >> 1;
      if (i == 3) begin wsb_l.push_back(4'hF); wsb_m.push_back(4'hF); end
      step();
    end
    check_word("loop_f");

    // Bits 1,0,0,0: MSB-first gives 8, LSB-first gives 1
    drive(0,0,0,1); step();
    bits = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive(1,0,bits[i],0);
      if (i == 3) begin wsb_l.push_back(4'h1); wsb_m.push_back(4'h8); end
      step();
    end
    check_word("word_8");

    // Force an overrun, then stop mid-word at fill=3 before reset
    for (int i = 0; i < 4; i++) begin drive(1,0,0,0); step(); end
    chk("pre_rst_overrun", int'(ov_l), 1);
    chk("pre_rst_q", int'(q_l), 1);
    for (int i = 0; i < 3; i++) begin drive(1,0,1,0); step(); end
    chk("pre_rst_fill", int'(f_l), 3);
    chk("pre_rst_valid", int'(v_l), 1);

    // areset between edges takes effect immediately
    ena = 1'b0;
    #2 areset = 1'b1;
    #1;
    chk("arst_q", int'(q_l), 0);
    chk("arst_q_msb", int'(q_m), 0);
    chk("arst_valid", int'(v_l), 0);
    chk("arst_fill", int'(f_l), 0);
    chk("arst_overrun", int'(ov_l), 0);
    @(negedge clk);
    areset = 1'b0;

    // A full word is needed after reset: 1,1,0,1
    bits = 4'b1011;
    for (int i = 0; i < 3; i++) begin drive(1,0,bits[i],0); step(); end
    chk("post_rst_valid", int'(v_l), 0);
    chk("post_rst_fill", int'(f_l), 3);
    drive(1,0,bits[3],0);
    wsb_l.push_back(4'hB); wsb_m.push_back(4'hD);
    step();
    check_word("post_rst");
    chk("post_rst_msb_valid", int'(v_m), 1);
    chk("post_rst_msb_fill", int'(f_m), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
